sp_ram_access_ctrl: RTL and testbench

SP_RAM_ACCESS_CTRL -- requirements
Module: sp_ram_access_ctrl

---
 rtl/sp_ram_access_ctrl.sv | 130 +++++++++++++
 tb/tb_sp_ram_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_access_ctrl.sv
// Single-port RAM access controller: accepts one read or write request at a time,
// drives the RAM from latched request registers, and returns read data via a valid/ready response.
module sp_ram_access_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic [CNT_WIDTH-1:0]  wr_cnt_r;
    logic [CNT_WIDTH-1:0]  rd_cnt_r;
    logic                  accept_s;

    // Next-state selection; the write/read decision is taken from req_we at the accepting edge.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = req_we ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
            ST_READ:  state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latches, read-data capture and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= '0;
            wdata_r    <= '0;
            rsp_data_r <= '0;
            wr_cnt_r   <= '0;
            rd_cnt_r   <= '0;
        end else begin
            if (accept_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (state_r == ST_READ) begin
                rsp_data_r <= ram_rdata;
            end
            if (state_r == ST_WRITE) begin
                wr_cnt_r <= wr_cnt_r + CNT_WIDTH'(1);
            end
            if ((state_r == ST_RESP) && rsp_ready) begin
                rd_cnt_r <= rd_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    // Status and strobe decode from the state register.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        busy      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_WRITE: ram_we    = 1'b1;
            ST_READ:  ram_we    = 1'b0;
            ST_RESP:  rsp_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;
    assign rsp_data  = rsp_data_r;
    assign wr_cnt    = wr_cnt_r;
    assign rd_cnt    = rd_cnt_r;

endmodule

// File: tb/tb_sp_ram_access_ctrl.sv
// Self-checking bench for sp_ram_access_ctrl: a RAM model plus a reference of expected
// memory contents and operation counts; a second instance exercises counter wrap.
module tb_sp_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [2:0] req_wdata = 3'd0;
    logic       rsp_ready = 1'b0;

    logic       req_ready, rsp_valid, ram_we, busy;
    logic [2:0] rsp_data, ram_wdata, ram_rdata;
    logic [1:0] ram_addr;
    logic [7:0] wr_cnt, rd_cnt;

    logic       req_ready2, rsp_valid2, ram_we2, busy2;
    logic [2:0] rsp_data2, ram_wdata2, ram_rdata2;
    logic [1:0] ram_addr2;
    logic [1:0] wr_cnt2, rd_cnt2;

    logic [2:0] mem [4];
    logic [2:0] mem_model [4];
    int         wr_exp = 0;
    int         rd_exp = 0;
    logic [2:0] rsp_exp = 3'd0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sp_ram_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    sp_ram_access_ctrl #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_rdata(ram_rdata2), .busy(busy2), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
    );

    // Combinational-read, clocked-write RAM seen by the main instance.
    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata2 = mem[ram_addr2];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_req();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 2'($urandom_range(0, 3));
        req_wdata = 3'($urandom_range(0, 7));
    endtask

    task automatic do_write(input logic [1:0] a, input logic [2:0] d, input bit keep);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        junk_req();
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata, busy, req_ready, rsp_valid} !== {1'b1, a, d, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_cycle we/addr/wdata/busy/rdy/rv got=%b%h%h%b%b%b want=1%h%h100",
                     ram_we, ram_addr, ram_wdata, busy, req_ready, rsp_valid, a, d);
        end
        mem_model[a] = d;
        wr_exp++;
        tick();
        n_tests++;
        if ({ram_we, busy, req_ready, rsp_valid, wr_cnt, rd_cnt, rsp_data, ram_addr} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 8'(wr_exp), 8'(rd_exp), rsp_exp, a}) begin
            n_fail++;
            $display("FAIL wr_done we/busy/rdy/rv/wr/rd/rdata/addr got=%b%b%b%b %h %h %h %h want=0010 %h %h %h %h",
                     ram_we, busy, req_ready, rsp_valid, wr_cnt, rd_cnt, rsp_data, ram_addr,
                     8'(wr_exp), 8'(rd_exp), rsp_exp, a);
        end
        n_tests++;
        if ({req_ready2, busy2, rsp_valid2, ram_we2, wr_cnt2, rd_cnt2, rsp_data2, ram_addr2, ram_wdata2} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'(wr_exp), 2'(rd_exp), rsp_exp, a, d}) begin
            n_fail++;
            $display("FAIL wr_done_cnt2 rdy/busy/rv/we/wr/rd got=%b%b%b%b %0d %0d want=1000 %0d %0d",
                     req_ready2, busy2, rsp_valid2, ram_we2, wr_cnt2, rd_cnt2, 2'(wr_exp), 2'(rd_exp));
        end
        req_valid = keep;
    endtask

    task automatic do_read(input logic [1:0] a, input int hold, input bit keep);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_accept_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 3'($urandom_range(0, 7));
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        n_tests++;
        if ({ram_we, ram_addr, busy, req_ready, rsp_valid, rsp_data} !== {1'b0, a, 1'b1, 1'b0, 1'b0, rsp_exp}) begin
            n_fail++;
            $display("FAIL rd_cycle we/addr/busy/rdy/rv/rdata got=%b%h%b%b%b %h want=0%h100 %h",
                     ram_we, ram_addr, busy, req_ready, rsp_valid, rsp_data, a, rsp_exp);
        end
        junk_req();
        rsp_exp = mem_model[a];
        tick();
        for (int i = 0; i <= hold; i++) begin
            n_tests++;
            if ({rsp_valid, rsp_data, req_ready, busy, ram_we, ram_addr} !== {1'b1, rsp_exp, 1'b0, 1'b1, 1'b0, a}) begin
                n_fail++;
                $display("FAIL rsp_hold[%0d] rv/rdata/rdy/busy/we/addr got=%b %h %b%b%b %h want=1 %h 010 %h",
                         i, rsp_valid, rsp_data, req_ready, busy, ram_we, ram_addr, rsp_exp, a);
            end
            rsp_ready = (i == hold);
            junk_req();
            tick();
        end
        rd_exp++;
        n_tests++;
        if ({rsp_valid, req_ready, busy, rd_cnt, rd_cnt2, wr_cnt, rsp_data} !==
            {1'b0, 1'b1, 1'b0, 8'(rd_exp), 2'(rd_exp), 8'(wr_exp), rsp_exp}) begin
            n_fail++;
            $display("FAIL rd_done rv/rdy/busy/rd/rd2/wr/rdata got=%b%b%b %h %h %h %h want=010 %h %h %h %h",
                     rsp_valid, req_ready, busy, rd_cnt, rd_cnt2, wr_cnt, rsp_data,
                     8'(rd_exp), 2'(rd_exp), 8'(wr_exp), rsp_exp);
        end
        rsp_ready = 1'b0;
        req_valid = keep;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) rst = 1'b0;
            n_tests++;
            if ({req_ready, rsp_valid, busy, ram_we, ram_addr, ram_wdata, rsp_data, wr_cnt, rd_cnt, wr_cnt2} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 8'd0, 8'd0, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_state[%0d] rdy/rv/busy/we/addr/wdata/rdata/wr/rd got=%b%b%b%b %h %h %h %h %h want=1000 0 0 0 00 00",
                         i, req_ready, rsp_valid, busy, ram_we, ram_addr, ram_wdata, rsp_data, wr_cnt, rd_cnt);
            end
        end
        tick();
        n_tests++;
        if ({req_ready, busy, ram_addr, ram_wdata} !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL post_reset_idle rdy/busy/addr/wdata got=%b%b %h %h want=10 0 0", req_ready, busy, ram_addr, ram_wdata);
        end
    endtask

    task automatic test_write();
        do_write(2'd2, 3'd5, 1'b0);
        do_write(2'd0, 3'd3, 1'b0);
        do_write(2'd1, 3'd7, 1'b0);
        do_write(2'd3, 3'd6, 1'b0);
    endtask

    task automatic test_read();
        do_read(2'd2, 0, 1'b0);
        do_read(2'd1, 4, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            do_write(2'(i % 4), 3'($urandom_range(1, 7)), 1'b1);
            do_read(2'(i % 4), 0, i != 7);
        end
        for (int i = 0; i < 4; i++) do_read(2'(i), 0, i != 3);
    endtask

    task automatic test_reset_midop();
        for (int ph = 0; ph < 3; ph++) begin
            do_write(2'd2, 3'd5, 1'b0);
            do_read(2'd2, 0, 1'b0);
            req_valid = 1'b1; req_we = (ph == 0); req_addr = 2'd3; req_wdata = 3'd6;
            tick();
            if (ph == 0) mem_model[3] = 3'd6;
            req_valid = 1'b0; rsp_ready = 1'b0;
            if (ph == 2) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            wr_exp = 0; rd_exp = 0; rsp_exp = 3'd0;
            n_tests++;
            if ({req_ready, rsp_valid, busy, ram_we, ram_addr, ram_wdata, rsp_data, wr_cnt, rd_cnt, wr_cnt2, rd_cnt2} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 8'd0, 8'd0, 2'd0, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_midop[%0d] rdy/rv/busy/we/addr/wdata/rdata/wr/rd got=%b%b%b%b %h %h %h %h %h want=1000 0 0 0 00 00",
                         ph, req_ready, rsp_valid, busy, ram_we, ram_addr, ram_wdata, rsp_data, wr_cnt, rd_cnt);
            end
            tick();
        end
    endtask

    task automatic test_cnt_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1; tick(); rst = 1'b0;
        wr_exp = 0; rd_exp = 0; rsp_exp = 3'd0;
        for (int k = 0; k < 5; k++) begin
            do_write(2'(k % 4), 3'($urandom_range(0, 7)), 1'b0);
            n_tests++;
            if (wr_cnt2 !== seq[k]) begin
                n_fail++; $display("FAIL cnt_wrap[%0d] got=%0d want=%0d", k, wr_cnt2, seq[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), (i != 39) && ($urandom_range(0, 1) == 1));
            else
                do_read(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), (i != 39) && ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_midop();
        test_cnt_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
